// File: rtl/sram_burst_controller.sv
// Burst SRAM controller: req/ack host handshake, incrementing multi-beat bursts, programmable wait states.
// Optional beat counters are enabled with the SRAM_PERF_CNT_EN macro.
module sram_burst_controller #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned LEN_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  ack_o,
    output logic                  busy_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  wdata_ready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic                  done_o,
`ifdef SRAM_PERF_CNT_EN
    input  logic                  cnt_clr_i,
    output logic [31:0]           rd_beats_o,
    output logic [31:0]           wr_beats_o,
`endif
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    inout  wire  [DATA_WIDTH-1:0] sram_data_io,
    output logic                  sram_ce_o,
    output logic                  sram_we_o,
    output logic                  sram_oe_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;
    logic                  wr_q, wr_d;
    logic [3:0]            wait_q, wait_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  done_q, done_d;
    logic                  rvalid_q, rvalid_d;
    logic                  bus_drive;

    // The ack cycle stays in IDLE with ack_q set; ack_q then moves the FSM to SETUP
    // and masks the still-asserted req_i so the request is latched only once.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        beats_d  = beats_q;
        wr_d     = wr_q;
        wait_d   = wait_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        done_d   = 1'b0;
        rvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ack_q) begin
                    state_d = SETUP;
                end else if (req_i) begin
                    addr_d  = addr_i;
                    wr_d    = wr_en_i;
                    beats_d = len_i;
                    ack_d   = 1'b1;
                end
            end
            SETUP: begin
                if (wr_q) begin
                    wdata_d = wdata_i;
                end
                wait_d  = '0;
                state_d = STROBE;
            end
            STROBE: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = HOLD;
                    if (!wr_q) begin
                        rdata_d  = sram_data_io;
                        rvalid_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            HOLD: begin
                if (beats_q != '0) begin
                    beats_d = beats_q - LEN_WIDTH'(1);
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            beats_q  <= '0;
            wr_q     <= 1'b0;
            wait_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            beats_q  <= beats_d;
            wr_q     <= wr_d;
            wait_q   <= wait_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Write data is held through HOLD so the SRAM sees it after we rises.
    assign bus_drive     = wr_q && ((state_q == STROBE) || (state_q == HOLD));
    assign sram_data_io  = bus_drive ? wdata_q : 'z;
    assign sram_addr_o   = addr_q;
    assign sram_ce_o     = (state_q == IDLE);
    assign sram_we_o     = !(wr_q && (state_q == STROBE));
    assign sram_oe_o     = !(!wr_q && ((state_q == SETUP) || (state_q == STROBE)));
    assign wdata_ready_o = wr_q && (state_q == SETUP);
    assign ack_o         = ack_q;
    assign busy_o        = (state_q != IDLE) || ack_q;
    assign done_o        = done_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;

`ifdef SRAM_PERF_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (cnt_clr_i) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end else if (state_q == HOLD) begin
            if (wr_q && (wr_cnt_q != '1)) begin
                wr_cnt_d = wr_cnt_q + 32'd1;
            end
            if (!wr_q && (rd_cnt_q != '1)) begin
                rd_cnt_d = rd_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_beats_o = rd_cnt_q;
    assign wr_beats_o = wr_cnt_q;
`endif

endmodule

// File: doc/sram_burst_controller.md
Name: sram_burst_controller

Overview:
Parametrised successor to the single-word sram_controller. It keeps the req/ack host handshake and adds multi-beat incrementing bursts, programmable SRAM wait states and per-beat data handshakes. It sits between an internal bus master and the asynchronous SRAM and drives the same sram_addr/sram_data/ce/we/oe pin set, so it plugs into the existing sram_model bench.

Parameters:
ADDR_WIDTH, 8, SRAM word-address width.
DATA_WIDTH, 16, SRAM data width.
WAIT_CYCLES, 0, extra strobe cycles per beat, legal range 0..15.
LEN_WIDTH, 4, width of the burst length field; max burst is 2^LEN_WIDTH beats.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_i  in  1  transaction request; held by the master until ack_o
wr_en_i  in  1  1=write burst, 0=read burst; sampled with req_i
addr_i  in  ADDR_WIDTH  start word address
len_i  in  LEN_WIDTH  number of beats minus 1
ack_o  out  1  one-cycle pulse: request accepted
busy_o  out  1  high from ack_o to the end of the last beat
wdata_i  in  DATA_WIDTH  write data for the current beat
wdata_ready_o  out  1  high in the cycle wdata_i is sampled
rdata_o  out  DATA_WIDTH  read data, registered
rdata_valid_o  out  1  one-cycle pulse per read beat
done_o  out  1  one-cycle pulse after the final beat
sram_addr_o  out  ADDR_WIDTH  SRAM address
sram_data_io  inout  DATA_WIDTH  SRAM data; high-Z unless this block is writing
sram_ce_o  out  1  chip enable, active-low
sram_we_o  out  1  write enable, active-low
sram_oe_o  out  1  output enable, active-low

Behaviour:
- Reset (synchronous): on any edge with rst_n=0, including mid-burst, FSM goes to IDLE.
  - ce, we and oe outputs driven 1; data bus high-Z.
  - ack, busy, wdata_ready, rdata_valid and done outputs 0; rdata_o=0; sram_addr_o=0.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: req_i=1 at an edge latches addr_i, wr_en_i and len_i; ack_o=1 in the next cycle; state goes to SETUP.
- SETUP (1 cycle):
  - sram_addr_o=beat address; ce=0.
  - Read: oe=0.
  - Write: wdata_ready_o=1; wdata_i is registered at the end of this cycle.
- STROBE (WAIT_CYCLES+1 cycles), counted by an internal wait counter:
  - Write: we=0, bus driven with the registered data.
  - Read: oe=0; sram_data_io is captured into rdata_o at the final STROBE edge; rdata_valid_o=1 in the following cycle.
- HOLD (1 cycle):
  - we=1, oe=1, ce=0; write data stays driven for hold time.
  - If beats remain: beat address +1, state goes to SETUP.
  - Otherwise: state goes to IDLE and done_o=1 in the next (IDLE) cycle.
- Beat period is WAIT_CYCLES+3 cycles.
- Address increments modulo 2^ADDR_WIDTH: 0xFF wraps to 0x00 at width 8.
- len_i=0 gives a single beat; the all-ones value gives 2^LEN_WIDTH beats.
- req_i is ignored outside IDLE; ack_o never pulses while busy_o=1.
- A req_i present in the done_o cycle (IDLE) is accepted, giving back-to-back bursts.
- busy_o=1 from the ack_o cycle through the final HOLD.
- The bus is never driven in IDLE, SETUP or any read state; there is no write/read overlap.

Optional Feature:
Macro SRAM_PERF_CNT_EN.
- Defined: adds ports
  - cnt_clr_i (in, 1): synchronous clear; has priority over increments in the same cycle; counters also reset by rst_n.
  - rd_beats_o (out, 32): saturating count of completed read beats.
  - wr_beats_o (out, 32): saturating count of completed write beats.
  - A beat counts as completed in its HOLD cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. WAIT_CYCLES=0: write 0x10=0xFACE (len 0), then read 0x10.
   - ack_o exactly 1 cycle after req_i.
   - done_o 4 cycles after ack_o.
   - rdata_o=0xFACE with rdata_valid_o pulsing once.
2. Burst write at addr 0xFE, len 3, data 0x1111/0x2222/0x3333/0x4444.
   - Writes land at 0xFE, 0xFF, 0x00, 0x01.
   - Burst read back returns the same data in order, 4 rdata_valid_o pulses spaced 3 cycles apart.
3. WAIT_CYCLES=2 instance, single read.
   - oe low exactly 4 consecutive cycles; beat period 5; data correct.
4. req_i held high during a len-7 burst.
   - Only one ack_o.
   - Second ack_o arrives 1 cycle after the done_o cycle.
5. rst_n=0 for 1 cycle during beat 2 of a 4-beat write to 0x20.
   - At that edge: strobes=1, bus high-Z, busy_o=0.
   - Read back: 0x20 holds new data, 0x22 and 0x23 hold old data.
6. SRAM_PERF_CNT_EN defined: after scenarios 1 and 2:
   - wr_beats_o=5, rd_beats_o=5.
   - cnt_clr_i pulse brings both to 0.
